// File: rtl/fft_frame_checker.sv
// Compares a DUT sample stream against a reference stream one frame at a time and reports squared error and mismatches.
// Optional first-error capture ports are built when FCHK_FIRST_ERR_EN is defined.
module fft_frame_checker #(
  parameter int SMPL_WDT  = 16,
  parameter int FRAME_LEN = 1024,
  parameter int TOL       = 0,
  parameter int ACC_WDT   = 48
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [2*SMPL_WDT-1:0]           s_axis_dut_tdata,
  input  logic                            s_axis_dut_tvalid,
  input  logic                            s_axis_dut_tlast,
  output logic                            s_axis_dut_tready,
  input  logic [2*SMPL_WDT-1:0]           s_axis_ref_tdata,
  input  logic                            s_axis_ref_tvalid,
  input  logic                            s_axis_ref_tlast,
  output logic                            s_axis_ref_tready,
  output logic                            busy,
  output logic                            frame_done,
  output logic [$clog2(FRAME_LEN+1)-1:0]  mism_cnt,
  output logic [ACC_WDT-1:0]              sq_err_acc,
  output logic                            sat,
  output logic                            tlast_err,
  output logic [15:0]                     frame_cnt
`ifdef FCHK_FIRST_ERR_EN
  ,
  output logic                            first_err_vld,
  output logic [$clog2(FRAME_LEN)-1:0]    first_err_idx,
  output logic [2*SMPL_WDT-1:0]           first_err_dut,
  output logic [2*SMPL_WDT-1:0]           first_err_ref
`endif
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam int CNT_W = $clog2(FRAME_LEN+1);
  localparam int DIF_W = SMPL_WDT + 1;
  localparam int SQ_W  = 2*SMPL_WDT + 3;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(FRAME_LEN-1);
  localparam logic [DIF_W-1:0]   TOL_V    = DIF_W'(TOL);
  localparam logic [ACC_WDT-1:0] ACC_MAX  = '1;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN1, DRAIN2, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             xfer;
  logic             v1, v2;
  logic             mis2;
  logic [SQ_W-1:0]  sq2;
  logic signed [DIF_W-1:0] dre, dim;

  logic signed [SMPL_WDT-1:0] dut_re, dut_im, ref_re, ref_im;
  assign dut_re = s_axis_dut_tdata[SMPL_WDT-1:0];
  assign dut_im = s_axis_dut_tdata[2*SMPL_WDT-1:SMPL_WDT];
  assign ref_re = s_axis_ref_tdata[SMPL_WDT-1:0];
  assign ref_im = s_axis_ref_tdata[2*SMPL_WDT-1:SMPL_WDT];

  // Both streams are joined: neither is accepted unless the other is also presenting a sample.
  assign xfer              = (state == RUN) && s_axis_dut_tvalid && s_axis_ref_tvalid;
  assign s_axis_dut_tready = xfer;
  assign s_axis_ref_tready = xfer;
  assign busy              = (state != IDLE);
  assign frame_done        = (state == DONE);

  logic [DIF_W-1:0]          abs_re, abs_im;
  logic signed [2*DIF_W-1:0] dre_x, dim_x, p_re, p_im;
  logic [SQ_W-1:0]           sq_c;
  logic                      mis_c;
  logic [ACC_WDT:0]          acc_sum;

  // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
  always_comb begin
    abs_re  = dre[DIF_W-1] ? DIF_W'(-dre) : DIF_W'(dre);
    abs_im  = dim[DIF_W-1] ? DIF_W'(-dim) : DIF_W'(dim);
    dre_x   = {{DIF_W{dre[DIF_W-1]}}, dre};
    dim_x   = {{DIF_W{dim[DIF_W-1]}}, dim};
    p_re    = dre_x * dre_x;
    p_im    = dim_x * dim_x;
    sq_c    = {1'b0, p_re} + {1'b0, p_im};
    mis_c   = (abs_re > TOL_V) || (abs_im > TOL_V);
    acc_sum = {1'b0, sq_err_acc} + (ACC_WDT+1)'(sq2);
  end

`ifdef FCHK_FIRST_ERR_EN
  logic [IDX_W-1:0]      idx1, idx2;
  logic [2*SMPL_WDT-1:0] dut1, dut2, ref1, ref2;
`endif

  // NOTE: pipeline data registers carry no reset; only their valid bits do, so garbage never reaches the results.
  always_ff @(posedge clk) begin
    if (xfer) begin
      dre <= $signed({dut_re[SMPL_WDT-1], dut_re}) - $signed({ref_re[SMPL_WDT-1], ref_re});
      dim <= $signed({dut_im[SMPL_WDT-1], dut_im}) - $signed({ref_im[SMPL_WDT-1], ref_im});
`ifdef FCHK_FIRST_ERR_EN
      idx1 <= idx;
      dut1 <= s_axis_dut_tdata;
      ref1 <= s_axis_ref_tdata;
`endif
    end
    if (v1) begin
      sq2  <= sq_c;
      mis2 <= mis_c;
`ifdef FCHK_FIRST_ERR_EN
      idx2 <= idx1;
      dut2 <= dut1;
      ref2 <= ref1;
`endif
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      mism_cnt   <= '0;
      sq_err_acc <= '0;
      sat        <= 1'b0;
      tlast_err  <= 1'b0;
      frame_cnt  <= '0;
`ifdef FCHK_FIRST_ERR_EN
      first_err_vld <= 1'b0;
      first_err_idx <= '0;
      first_err_dut <= '0;
      first_err_ref <= '0;
`endif
    end else begin
      v1 <= xfer;
      v2 <= v1;

      if (v2) begin
        mism_cnt <= mism_cnt + CNT_W'(mis2);
        if (acc_sum[ACC_WDT] || sat) begin
          sq_err_acc <= ACC_MAX;
          sat        <= 1'b1;
        end else begin
          sq_err_acc <= acc_sum[ACC_WDT-1:0];
        end
`ifdef FCHK_FIRST_ERR_EN
        if (mis2 && !first_err_vld) begin
          first_err_vld <= 1'b1;
          first_err_idx <= idx2;
          first_err_dut <= dut2;
          first_err_ref <= ref2;
        end
`endif
      end

      case (state)
        IDLE: if (start) begin
          state      <= RUN;
          idx        <= '0;
          mism_cnt   <= '0;
          sq_err_acc <= '0;
          sat        <= 1'b0;
          tlast_err  <= 1'b0;
`ifdef FCHK_FIRST_ERR_EN
          first_err_vld <= 1'b0;
          first_err_idx <= '0;
          first_err_dut <= '0;
          first_err_ref <= '0;
`endif
        end
        RUN: if (xfer) begin
          // Frame length is fixed by the sample count; tlast only raises a flag.
          if (idx == LAST_IDX) begin
            if (!s_axis_dut_tlast || !s_axis_ref_tlast) tlast_err <= 1'b1;
            state <= DRAIN1;
          end else begin
            if (s_axis_dut_tlast || s_axis_ref_tlast) tlast_err <= 1'b1;
            idx <= idx + 1'b1;
          end
        end
        DRAIN1:  state <= DRAIN2;
        DRAIN2: begin
          state     <= DONE;
          frame_cnt <= frame_cnt + 16'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_checker.sv
// Randomized self-checking bench for fft_frame_checker; two instances (ACC_WDT 48 and 34) share one stimulus.
// Expected results come from a per-frame arithmetic model over the sample arrays.
module tb_fft_frame_checker;
  localparam int SW = 16;
  localparam int FL = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [2*SW-1:0] dut_tdata = '0, ref_tdata = '0;
  logic dut_tvalid = 1'b0, dut_tlast = 1'b0, ref_tvalid = 1'b0, ref_tlast = 1'b0;

  logic a_dut_tready, a_ref_tready, a_busy, a_frame_done, a_sat, a_tlast_err;
  logic [3:0]  a_mism_cnt;
  logic [47:0] a_sq_err_acc;
  logic [15:0] a_frame_cnt;
  logic b_dut_tready, b_ref_tready, b_busy, b_frame_done, b_sat, b_tlast_err;
  logic [3:0]  b_mism_cnt;
  logic [33:0] b_sq_err_acc;
  logic [15:0] b_frame_cnt;
`ifdef FCHK_FIRST_ERR_EN
  logic a_fe_vld;
  logic [2:0] a_fe_idx;
  logic [2*SW-1:0] a_fe_dut, a_fe_ref;
  logic b_fe_vld;
  logic [2:0] b_fe_idx;
  logic [2*SW-1:0] b_fe_dut, b_fe_ref;
`endif

  always #5 clk = ~clk;

  fft_frame_checker #(.SMPL_WDT(SW), .FRAME_LEN(FL), .TOL(0), .ACC_WDT(48)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start),
    .s_axis_dut_tdata(dut_tdata), .s_axis_dut_tvalid(dut_tvalid), .s_axis_dut_tlast(dut_tlast),
    .s_axis_dut_tready(a_dut_tready),
    .s_axis_ref_tdata(ref_tdata), .s_axis_ref_tvalid(ref_tvalid), .s_axis_ref_tlast(ref_tlast),
    .s_axis_ref_tready(a_ref_tready),
    .busy(a_busy), .frame_done(a_frame_done), .mism_cnt(a_mism_cnt), .sq_err_acc(a_sq_err_acc),
    .sat(a_sat), .tlast_err(a_tlast_err), .frame_cnt(a_frame_cnt)
`ifdef FCHK_FIRST_ERR_EN
    , .first_err_vld(a_fe_vld), .first_err_idx(a_fe_idx), .first_err_dut(a_fe_dut), .first_err_ref(a_fe_ref)
`endif
  );

  fft_frame_checker #(.SMPL_WDT(SW), .FRAME_LEN(FL), .TOL(0), .ACC_WDT(34)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start),
    .s_axis_dut_tdata(dut_tdata), .s_axis_dut_tvalid(dut_tvalid), .s_axis_dut_tlast(dut_tlast),
    .s_axis_dut_tready(b_dut_tready),
    .s_axis_ref_tdata(ref_tdata), .s_axis_ref_tvalid(ref_tvalid), .s_axis_ref_tlast(ref_tlast),
    .s_axis_ref_tready(b_ref_tready),
    .busy(b_busy), .frame_done(b_frame_done), .mism_cnt(b_mism_cnt), .sq_err_acc(b_sq_err_acc),
    .sat(b_sat), .tlast_err(b_tlast_err), .frame_cnt(b_frame_cnt)
`ifdef FCHK_FIRST_ERR_EN
    , .first_err_vld(b_fe_vld), .first_err_idx(b_fe_idx), .first_err_dut(b_fe_dut), .first_err_ref(b_fe_ref)
`endif
  );

  int checks = 0;
  int errors = 0;
  int exp_frames = 0;

  logic signed [SW-1:0] d_re [FL];
  logic signed [SW-1:0] d_im [FL];
  logic signed [SW-1:0] r_re [FL];
  logic signed [SW-1:0] r_im [FL];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] clip(input logic [63:0] v, input int w);
    logic [63:0] mx;
    mx = (64'd1 << w) - 64'd1;
    return (v > mx) ? mx : v;
  endfunction

  // Reference model: squared error and mismatch count straight from the sample arrays.
  task automatic check_results(input string name, input int tl_d, input int tl_r);
    logic [63:0] tot;
    int mism, first, er, ei;
    bit terr;
    tot = 0; mism = 0; first = -1;
    for (int i = 0; i < FL; i++) begin
      er = int'(d_re[i]) - int'(r_re[i]);
      ei = int'(d_im[i]) - int'(r_im[i]);
      tot += 64'(longint'(er) * er) + 64'(longint'(ei) * ei);
      if (er != 0 || ei != 0) begin
        mism++;
        if (first < 0) first = i;
      end
    end
    terr = (tl_d != FL-1) || (tl_r != FL-1);
    check({name, "/a_acc"},   a_sq_err_acc, clip(tot, 48));
    check({name, "/a_sat"},   a_sat, tot > clip(tot, 48));
    check({name, "/b_acc"},   b_sq_err_acc, clip(tot, 34));
    check({name, "/b_sat"},   b_sat, tot > clip(tot, 34));
    check({name, "/a_mism"},  a_mism_cnt, mism);
    check({name, "/b_mism"},  b_mism_cnt, mism);
    check({name, "/a_tlerr"}, a_tlast_err, terr);
    check({name, "/b_tlerr"}, b_tlast_err, terr);
    check({name, "/a_fcnt"},  a_frame_cnt, exp_frames);
    check({name, "/b_fcnt"},  b_frame_cnt, exp_frames);
`ifdef FCHK_FIRST_ERR_EN
    check({name, "/fe_vld"}, a_fe_vld, first >= 0);
    check({name, "/b_fe_vld"}, b_fe_vld, first >= 0);
    if (first >= 0) begin
      check({name, "/fe_idx"}, a_fe_idx, first);
      check({name, "/fe_dut"}, a_fe_dut, {d_im[first], d_re[first]});
      check({name, "/fe_ref"}, a_fe_ref, {r_im[first], r_re[first]});
    end
`endif
  endtask

  task automatic check_all_zero(input string name);
    check({name, "/a_tready"}, {a_dut_tready, a_ref_tready, b_dut_tready, b_ref_tready}, 0);
    check({name, "/busy"},  {a_busy, b_busy}, 0);
    check({name, "/done"},  {a_frame_done, b_frame_done}, 0);
    check({name, "/mism"},  {a_mism_cnt, b_mism_cnt}, 0);
    check({name, "/a_acc"}, a_sq_err_acc, 0);
    check({name, "/b_acc"}, b_sq_err_acc, 0);
    check({name, "/flags"}, {a_sat, a_tlast_err, b_sat, b_tlast_err}, 0);
    check({name, "/fcnt"},  {a_frame_cnt, b_frame_cnt}, 0);
  endtask

  // mode 0: both valid always; 1: ref valid on alternate cycles; 2: random valids plus stray start pulses.
  task automatic run_frame(input string name, input int mode, input int tl_d, input int tl_r, input int abort_at);
    int idx, cyc;
    bit dv, rv;
    idx = 0; cyc = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (idx < FL && cyc < 200) begin
      if (abort_at >= 0 && idx == abort_at) break;
      case (mode)
        0:       begin dv = 1'b1; rv = 1'b1; end
        1:       begin dv = 1'b1; rv = (cyc % 2 == 0); end
        default: begin
          dv = ($urandom_range(0, 3) != 0);
          rv = ($urandom_range(0, 3) != 0);
          start = ($urandom_range(0, 5) == 0);
        end
      endcase
      dut_tvalid = dv;
      ref_tvalid = rv;
      dut_tdata  = {d_im[idx], d_re[idx]};
      ref_tdata  = {r_im[idx], r_re[idx]};
      dut_tlast  = (idx == tl_d);
      ref_tlast  = (idx == tl_r);
      @(negedge clk);
      check({name, "/dut_tready"}, {a_dut_tready, b_dut_tready}, {2{dv & rv}});
      check({name, "/ref_tready"}, {a_ref_tready, b_ref_tready}, {2{dv & rv}});
      if (dv && rv) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; dut_tvalid = 1'b0; ref_tvalid = 1'b0; dut_tlast = 1'b0; ref_tlast = 1'b0;
    if (abort_at >= 0) return;
    if (idx != FL) check({name, "/timeout"}, idx, FL);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check({name, "/done_k"}, {a_frame_done, b_frame_done}, {2{k == 3}});
      if (k == 3) begin
        exp_frames++;
        check_results(name, tl_d, tl_r);
      end
    end
    check({name, "/idle"}, {a_busy, b_busy}, 0);
    check_results({name, "_held"}, tl_d, tl_r);
  endtask

  task automatic set_ramp();
    for (int i = 0; i < FL; i++) begin
      r_re[i] = 16'(i * 100);
      r_im[i] = 16'(-i * 50);
      d_re[i] = r_re[i];
      d_im[i] = r_im[i];
    end
  endtask

  task automatic set_random(input bit wide);
    for (int i = 0; i < FL; i++) begin
      r_re[i] = 16'($urandom);
      r_im[i] = 16'($urandom);
      if (wide) begin
        d_re[i] = 16'($urandom);
        d_im[i] = 16'($urandom);
      end else begin
        d_re[i] = ($urandom_range(0, 1) == 0) ? r_re[i] : 16'(r_re[i] + $urandom_range(0, 6) - 3);
        d_im[i] = ($urandom_range(0, 1) == 0) ? r_im[i] : 16'(r_im[i] + $urandom_range(0, 6) - 3);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    #1 rst_n = 1'b1;

    set_ramp();
    run_frame("ramp", 0, 7, 7, -1);

    set_ramp();
    d_re[3] = 16'(d_re[3] + 2);
    d_im[3] = 16'(d_im[3] - 1);
    run_frame("idx3", 0, 7, 7, -1);

    set_ramp();
    run_frame("alt_ref", 1, 7, 7, -1);

    set_ramp();
    run_frame("tlast5", 0, 5, 7, -1);

    set_ramp();
    run_frame("no_ref_tlast", 2, 7, -1, -1);

    for (int i = 0; i < FL; i++) begin
      d_re[i] = 16'sh7FFF;
      r_re[i] = 16'sh8000;
      d_im[i] = 16'(i * 3);
      r_im[i] = d_im[i];
    end
    run_frame("sat", 0, 7, 7, -1);

    for (int f = 0; f < 6; f++) begin
      set_random(f == 5);
      run_frame($sformatf("rand%0d", f), 2, 7, 7, -1);
    end

    set_random(1'b0);
    d_re[0] = 16'(r_re[0] + 5);
    run_frame("abort", 0, 7, 7, 4);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("abort_rst");
    exp_frames = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("abort_nodone", {a_frame_done, b_frame_done, a_busy}, 0);
    end

    set_ramp();
    run_frame("after_abort", 0, 7, 7, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
